// File: rtl/dpram_pingpong_ctrl.sv
// Ping-pong controller for the 64 KB asymmetric dual-port RAM.
// Bytes fill two banks alternately on port A; full banks drain as words on port B.
module dpram_pingpong_ctrl #(
  parameter int FRAME_BYTES = 32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        rd_req,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic [15:0] rd_len,
  output logic [1:0]  bank_full,
  output logic [15:0] addra,
  output logic [7:0]  dina,
  output logic        ena,
  output logic        wea,
  output logic [13:0] addrb,
  output logic        enb,
  input  logic [31:0] doutb
);

  typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

  localparam logic [14:0] WMAX = 15'(FRAME_BYTES - 1);

  state_t      state, state_nx;
  logic        wbank, rbank;
  logic [14:0] wptr;
  logic [15:0] len0, len1;
  logic [13:0] k, nwords;
  logic        accept, close, start, last_k;
  logic [1:0]  set_v, clr_v;

  assign in_ready = !bank_full[wbank];
  assign accept   = in_valid & in_ready;
  assign close    = accept & (in_last | (wptr == WMAX));
  assign nwords   = 14'((rd_len + 16'd3) >> 2);
  assign last_k   = (k == nwords - 14'd1);
  assign rd_data  = doutb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank <= 1'b0;
      wptr  <= '0;
      len0  <= '0;
      len1  <= '0;
      ena   <= 1'b0;
      wea   <= 1'b0;
      addra <= '0;
      dina  <= '0;
    end else begin
      ena <= accept;
      wea <= accept;
      if (accept) begin
        addra <= {wbank, wptr};
        dina  <= in_data;
        if (close) begin
          wptr  <= '0;
          wbank <= ~wbank;
          if (wbank) len1 <= {1'b0, wptr} + 16'd1;
          else       len0 <= {1'b0, wptr} + 16'd1;
        end else begin
          wptr <= wptr + 15'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    enb      = 1'b0;
    addrb    = '0;
    start    = 1'b0;
    clr_v    = '0;
    set_v    = '0;
    if (close) set_v[wbank] = 1'b1;
    unique case (state)
      IDLE: begin
        if (rd_req && bank_full[rbank]) begin
          start    = 1'b1;
          state_nx = READ;
        end
      end
      READ: begin
        enb   = 1'b1;
        addrb = {rbank, k[12:0]};
        if (last_k) state_nx = FLUSH;
      end
      FLUSH: begin
        clr_v[rbank] = 1'b1;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // bank_full set (writer) and clear (reader) always target different bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_full <= '0;
      rbank     <= 1'b0;
      k         <= '0;
      rd_len    <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      bank_full <= (bank_full | set_v) & ~clr_v;
      rd_valid  <= enb;
      rd_last   <= enb & last_k;
      if (start) begin
        rd_len <= rbank ? len1 : len0;
        k      <= '0;
      end else if (enb) begin
        k <= k + 14'd1;
      end
      if (state == FLUSH) rbank <= ~rbank;
    end
  end

endmodule
